// File: rtl/lsu_pkg.sv
// Shared load/store definitions: RV32I funct3 width codes, response error
// codes, load/store unit state encodings and request legality helpers.
// Used by load_store_unit, load_extend, DataMemory and the decoder.
package lsu_pkg;

  // RV32I load/store funct3 codes (stores use only B/H/W)
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // resp_error codes
  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_FUNCT3   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  // Load/store unit state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Loads accept B/H/W/BU/HU; stores accept B/H/W only.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    logic bad;
    if (is_store) bad = (f3 > F3_W);
    else          bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    return bad;
  endfunction

  // Width comes from funct3[1:0] (00 byte, 01 half, 10 word) for legal codes.
  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = a[0];
      2'b10:   mis = (a != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core/memory handshake bundle for load_store_unit.
//   modport slave  : the load/store unit (accepts core requests, drives memory)
//   modport master : the surrounding system (execute stage issuing requests
//                    and DataMemory answering accesses)
// Core side : req_valid/req_ready handshake, request fields, one-cycle response,
//             busy_out stall indication.
// Memory side: address, read/write strobes, store width, lane mask, write data,
//             mem_ready completion and read data.
interface load_store_unit_if;
  // core request / response
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_store_data;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_error;
  logic        busy_out;
  // data memory
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_store_sel;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_write_data;
  logic        mem_ready;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_address, req_store_data, req_rd,
    output req_ready, resp_valid, resp_data, resp_rd, resp_error, busy_out,
    output mem_address, mem_read, mem_write, mem_store_sel, mem_byte_enable, mem_write_data,
    input  mem_ready, mem_read_data
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_address, req_store_data, req_rd,
    input  req_ready, resp_valid, resp_data, resp_rd, resp_error, busy_out,
    input  mem_address, mem_read, mem_write, mem_store_sel, mem_byte_enable, mem_write_data,
    output mem_ready, mem_read_data
  );
endinterface

// File: rtl/load_extend.sv
// Load result extraction: selects the byte/half lane of a memory word by
// address low bits and sign- or zero-extends it according to funct3.
//   word_in  : 32-bit word returned by memory
//   byte_sel : address bits [1:0] (byte lane; bit 1 selects the half lane)
//   funct3   : load funct3 (LB/LH/LW/LBU/LHU); other codes return 0
//   result   : extended 32-bit load value
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [1:0]  byte_sel,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (byte_sel)
      2'd0:    lane_b = word_in[7:0];
      2'd1:    lane_b = word_in[15:8];
      2'd2:    lane_b = word_in[23:16];
      default: lane_b = word_in[31:24];
    endcase
    lane_h = byte_sel[1] ? word_in[31:16] : word_in[15:0];

    case (funct3)
      F3_B:    result = {{24{lane_b[7]}}, lane_b};
      F3_H:    result = {{16{lane_h[15]}}, lane_h};
      F3_W:    result = word_in;
      F3_BU:   result = {24'd0, lane_b};
      F3_HU:   result = {16'd0, lane_h};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the core-to-DataMemory interface.
// Accepts one request at a time from the execute stage, rejects illegal or
// misaligned requests without touching memory, otherwise strobes memory
// until mem_ready (or a MEM_TIMEOUT-cycle abort) and returns a one-cycle
// response with the extended load data and an error code.
// Ports:
//   clk_in : clock, rising edge
//   rst_in : synchronous active-high reset
//   bus    : load_store_unit_if.slave (core request/response + memory side)
// Parameters:
//   MEM_TIMEOUT : cycles the access strobe may stay up without mem_ready (>=1)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  load_store_unit_if.slave  bus
);

  localparam int unsigned       CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;

  logic [1:0]       state_q,    state_d;
  logic [31:0]      addr_q,     addr_d;
  logic [2:0]       f3_q,       f3_d;
  logic             store_q,    store_d;
  logic [3:0]       be_q,       be_d;
  logic [31:0]      wdata_q,    wdata_d;
  logic [4:0]       rd_q,       rd_d;
  logic [31:0]      rdata_q,    rdata_d;
  logic [1:0]       err_q,      err_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  logic [31:0]      load_value;

  load_extend u_load_extend (
    .word_in  (bus.mem_read_data),
    .byte_sel (addr_q[1:0]),
    .funct3   (f3_q),
    .result   (load_value)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    store_d = store_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_address;
          f3_d    = bus.req_funct3;
          store_d = bus.req_is_store;
          rd_d    = bus.req_rd;
          rdata_d = '0;
          cnt_d   = '0;

          // Lane mask and replication follow DataMemory lane ordering
          // (lane 0 = bits [7:0] = lowest byte address).
          be_d    = '0;
          wdata_d = '0;
          if (bus.req_is_store) begin
            case (bus.req_funct3)
              F3_B: begin
                be_d    = 4'b0001 << bus.req_address[1:0];
                wdata_d = {4{bus.req_store_data[7:0]}};
              end
              F3_H: begin
                be_d    = bus.req_address[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{bus.req_store_data[15:0]}};
              end
              F3_W: begin
                be_d    = 4'b1111;
                wdata_d = bus.req_store_data;
              end
              default: ;
            endcase
          end

          // Illegal funct3 is checked before alignment.
          if (f3_illegal(bus.req_is_store, bus.req_funct3)) begin
            err_d   = ERR_FUNCT3;
            state_d = ST_RESP;
          end else if (addr_misaligned(bus.req_funct3, bus.req_address[1:0])) begin
            err_d   = ERR_MISALIGN;
            state_d = ST_RESP;
          end else begin
            err_d   = ERR_OK;
            state_d = ST_ACCESS;
          end
        end
      end

      ST_ACCESS: begin
        if (bus.mem_ready) begin
          rdata_d = store_q ? '0 : load_value;
          err_d   = ERR_OK;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = ERR_TIMEOUT;
          state_d = ST_RESP;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      store_q <= store_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ready       = (state_q == ST_IDLE);
  assign bus.busy_out        = (state_q != ST_IDLE);
  assign bus.resp_valid      = (state_q == ST_RESP);
  assign bus.resp_data       = rdata_q;
  assign bus.resp_rd         = rd_q;
  assign bus.resp_error      = err_q;

  assign bus.mem_address     = addr_q;
  assign bus.mem_read        = (state_q == ST_ACCESS) && !store_q;
  assign bus.mem_write       = (state_q == ST_ACCESS) && store_q;
  assign bus.mem_store_sel   = f3_q;
  assign bus.mem_byte_enable = be_q;
  assign bus.mem_write_data  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the stimulus thread issues directed
// requests, plays the memory side, checks strobes/lanes and pushes the
// expected response; a monitor pops and compares each resp_valid pulse.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned TO = 5;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic [1:0]  err;
    int          lat;
    int          acc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  load_store_unit_if bus();

  load_store_unit #(.MEM_TIMEOUT(TO)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL resp_unexpected: got resp rd=%0d err=%b expected none",
                   bus.resp_rd, bus.resp_error);
        end else begin
          e = sb.pop_front();
          check("resp_data",    bus.resp_data, e.data);
          check("resp_rd",      32'(bus.resp_rd), 32'(e.rd));
          check("resp_error",   32'(bus.resp_error), 32'(e.err));
          check("resp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end
    end
  end

  // Present one request at a negedge; it is accepted on the next rising edge.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd, input logic push,
                       input logic [31:0] ed, input logic [1:0] ee, input int el);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      tests++;
      fails++;
      $display("FAIL req_ready_wait: got req_ready=%b expected 1", bus.req_ready);
    end
    bus.req_is_store   = st;
    bus.req_funct3     = f3;
    bus.req_address    = a;
    bus.req_store_data = d;
    bus.req_rd         = rd;
    bus.req_valid      = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (push) begin
      e.data = ed; e.rd = rd; e.err = ee; e.lat = el; e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  // Memory side for a legal access: mem_ready after 'delay' wait cycles.
  task automatic serve(input logic st, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] rdata, input int delay);
    for (int i = 0; i <= delay; i++) begin
      if (i == delay) begin
        bus.mem_ready     = 1'b1;
        bus.mem_read_data = rdata;
      end
      @(negedge clk);
      check("mem_read",   32'(bus.mem_read), 32'(!st));
      check("mem_write",  32'(bus.mem_write), 32'(st));
      check("mem_addr",   bus.mem_address, a);
      check("mem_be",     32'(bus.mem_byte_enable), 32'(be));
      if (st) check("mem_wdata", bus.mem_write_data, wd);
      @(posedge clk);
      #1;
    end
    bus.mem_ready     = 1'b0;
    bus.mem_read_data = 32'h5A5A_5A5A;
  endtask

  task automatic no_access();
    @(negedge clk);
    check("no_strobe", 32'({bus.mem_read, bus.mem_write}), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_funct3 = '0;
    bus.req_address = '0; bus.req_store_data = '0; bus.req_rd = '0;
    bus.mem_ready = 1'b0; bus.mem_read_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready",  32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_busy",       32'(bus.busy_out), 32'd0);
    check("rst_strobes",    32'({bus.mem_read, bus.mem_write}), 32'd0);
    check("rst_be",         32'(bus.mem_byte_enable), 32'd0);
    check("rst_addr",       bus.mem_address, 32'd0);
    check("rst_wdata",      bus.mem_write_data, 32'd0);

    // Stores
    issue(1, F3_W, 32'h10, 32'hDEADBEEF, 5'd1, 1, 32'h0, ERR_OK, 2);
    serve(1, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0, 0);
    issue(1, F3_B, 32'h13, 32'h000000A5, 5'd2, 1, 32'h0, ERR_OK, 2);
    serve(1, 32'h13, 4'b1000, 32'hA5A5A5A5, 32'h0, 0);
    issue(1, F3_H, 32'h12, 32'h00001234, 5'd3, 1, 32'h0, ERR_OK, 2);
    serve(1, 32'h12, 4'b1100, 32'h12341234, 32'h0, 0);
    issue(1, F3_B, 32'h10, 32'hFFFFFF3C, 5'd20, 1, 32'h0, ERR_OK, 2);
    serve(1, 32'h10, 4'b0001, 32'h3C3C3C3C, 32'h0, 0);
    issue(1, F3_H, 32'h10, 32'hABCD5678, 5'd21, 1, 32'h0, ERR_OK, 4);
    serve(1, 32'h10, 4'b0011, 32'h56785678, 32'h0, 2);

    // Loads
    issue(0, F3_B,  32'h11, 32'h0, 5'd4, 1, 32'hFFFFFF80, ERR_OK, 2);
    serve(0, 32'h11, 4'b0000, 32'h0, 32'h000080FF, 0);
    issue(0, F3_BU, 32'h11, 32'h0, 5'd5, 1, 32'h00000080, ERR_OK, 2);
    serve(0, 32'h11, 4'b0000, 32'h0, 32'h000080FF, 0);
    issue(0, F3_H,  32'h12, 32'h0, 5'd6, 1, 32'hFFFF8001, ERR_OK, 2);
    serve(0, 32'h12, 4'b0000, 32'h0, 32'h80010000, 0);
    issue(0, F3_HU, 32'h10, 32'h0, 5'd7, 1, 32'h00009ABC, ERR_OK, 2);
    serve(0, 32'h10, 4'b0000, 32'h0, 32'h12349ABC, 0);
    issue(0, F3_B,  32'h13, 32'h0, 5'd8, 1, 32'h0000007F, ERR_OK, 2);
    serve(0, 32'h13, 4'b0000, 32'h0, 32'h7F000000, 0);
    issue(0, F3_W,  32'h20, 32'h0, 5'd22, 1, 32'hCAFEF00D, ERR_OK, 4);
    serve(0, 32'h20, 4'b0000, 32'h0, 32'hCAFEF00D, 2);

    // Rejected requests never reach memory
    issue(0, F3_W, 32'h06, 32'h0, 5'd9,  1, 32'h0, ERR_MISALIGN, 1);
    no_access();
    issue(0, 3'd3, 32'h00, 32'h0, 5'd10, 1, 32'h0, ERR_FUNCT3, 1);
    no_access();
    issue(1, F3_H, 32'h11, 32'h0, 5'd11, 1, 32'h0, ERR_MISALIGN, 1);
    no_access();
    issue(1, 3'd3, 32'h13, 32'h0, 5'd23, 1, 32'h0, ERR_FUNCT3, 1);
    no_access();
    issue(0, 3'd6, 32'h01, 32'h0, 5'd24, 1, 32'h0, ERR_FUNCT3, 1);
    no_access();

    // Timeout, then a normal load
    issue(0, F3_W, 32'h40, 32'h0, 5'd12, 1, 32'h0, ERR_TIMEOUT, TO + 1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.mem_read !== 1'b1) break;
      n++;
    end
    check("timeout_strobe_cycles", 32'(n), 32'(TO));
    issue(0, F3_W, 32'h44, 32'h0, 5'd13, 1, 32'h11223344, ERR_OK, 2);
    serve(0, 32'h44, 4'b0000, 32'h0, 32'h11223344, 0);

    // mem_ready while idle is ignored
    @(negedge clk);
    bus.mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_mem_ready_busy", 32'(bus.busy_out), 32'd0);
    end
    bus.mem_ready = 1'b0;

    // req_valid held through RESP must not be taken as a new request
    issue(0, F3_W, 32'h06, 32'h0, 5'd14, 1, 32'h0, ERR_MISALIGN, 1);
    bus.req_valid = 1'b1;
    bus.req_rd    = 5'd15;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("resp_ignore_busy",  32'(bus.busy_out), 32'd0);
    check("resp_ignore_ready", 32'(bus.req_ready), 32'd1);

    // Reset during ACCESS: strobe drops, no response
    issue(0, F3_W, 32'h80, 32'h0, 5'd16, 0, 32'h0, ERR_OK, 0);
    @(negedge clk);
    check("rst_mid_strobe_before", 32'(bus.mem_read), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_strobes", 32'({bus.mem_read, bus.mem_write}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    check("rst_mid_busy",  32'(bus.busy_out), 32'd0);

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
